// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU sharing block and its round-robin arbiter.
//   - WIDTH_DEF / OPW_DEF : default operand and ALU-control widths
//   - ALU_* localparams   : ALU control encodings
//   - state_t             : sharing FSM state encoding
//   - idx_width()         : bits needed for a requester index (2..4 requesters)
// ----------------------------------------------------------------------------
package alu_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int OPW_DEF   = 3;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_NOT   = 3'b100;
  localparam logic [2:0] ALU_PASSA = 3'b101;
  localparam logic [2:0] ALU_PASSB = 3'b110;
  localparam logic [2:0] ALU_NOP   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Index width for 2..4 requesters; kept at least 1 bit.
  function automatic int idx_width(input int n);
    return (n > 2) ? 2 : 1;
  endfunction

endpackage

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Combinational N_REQ-way round-robin arbiter. The search starts at the
// requester after i_rr_ptr and wraps, so the last winner has lowest priority.
// Ports:
//   i_req_valid  [N_REQ]  request lines
//   i_rr_ptr     [IDX_W]  index of the previous winner
//   o_grant      [N_REQ]  one-hot grant (all zero when nothing is requested)
//   o_grant_idx  [IDX_W]  binary index of the winner (0 when none)
//   o_grant_any           any request present
// ----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int IDX_W = 1
) (
  input  logic [N_REQ-1:0] i_req_valid,
  input  logic [IDX_W-1:0] i_rr_ptr,
  output logic [N_REQ-1:0] o_grant,
  output logic [IDX_W-1:0] o_grant_idx,
  output logic             o_grant_any
);

  always_comb begin
    logic [IDX_W-1:0] v_cand;
    o_grant     = '0;
    o_grant_idx = '0;
    o_grant_any = 1'b0;
    v_cand      = '0;
    // Offsets 1..N_REQ: the previous winner is visited last.
    for (int k = 1; k <= N_REQ; k++) begin
      v_cand = IDX_W'((int'(i_rr_ptr) + k) % N_REQ);
      if (!o_grant_any && i_req_valid[v_cand]) begin
        o_grant_any     = 1'b1;
        o_grant_idx     = v_cand;
        o_grant[v_cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// ----------------------------------------------------------------------------
// alu_share_arbiter
// Shares one external combinational ALU among N_REQ requesters. One operation
// is in flight at a time: accept (IDLE) -> drive ALU for one cycle (EXEC) ->
// hold the result for the owner until it is taken (RESP).
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Requesters hold req_valid and payload until req_ready; the block
// holds rsp_valid/rsp_result/rsp_zero until rsp_ready of the owner.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready [N]    request channel per requester
//   req_op/req_a/req_b         packed per-requester payload, slice i
//   rsp_valid/rsp_ready [N]    response channel per requester
//   rsp_result, rsp_zero       shared response bus (valid with rsp_valid)
//   alu_srca/srcb/ctrl         registered drive to the ALU
//   alu_result, alu_zero       ALU outputs, sampled at the end of EXEC
//   busy                       state is not IDLE
//   dbg_state                  current FSM state encoding
// ----------------------------------------------------------------------------
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int OPW   = OPW_DEF,
  parameter int N_REQ = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*OPW-1:0]   req_op,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]       rsp_valid,
  input  logic [N_REQ-1:0]       rsp_ready,
  output logic [WIDTH-1:0]       rsp_result,
  output logic                   rsp_zero,
  output logic [WIDTH-1:0]       alu_srca,
  output logic [WIDTH-1:0]       alu_srcb,
  output logic [OPW-1:0]         alu_ctrl,
  input  logic [WIDTH-1:0]       alu_result,
  input  logic                   alu_zero,
  output logic                   busy,
  output logic [1:0]             dbg_state
);

  localparam int             IDX_W     = idx_width(N_REQ);
  // Control value that makes the ALU produce 0 while it is not in use.
  localparam logic [OPW-1:0] CTRL_IDLE = OPW'(ALU_NOP);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_owner;
  logic [IDX_W-1:0] r_rr_ptr;
  logic [WIDTH-1:0] r_srca;
  logic [WIDTH-1:0] r_srcb;
  logic [OPW-1:0]   r_ctrl;
  logic [WIDTH-1:0] r_rsp_result;
  logic             r_rsp_zero;

  logic [N_REQ-1:0] w_grant;
  logic [IDX_W-1:0] w_grant_idx;
  logic             w_grant_any;
  logic             w_accept;
  logic             w_rsp_done;
  logic [OPW-1:0]   w_sel_op;
  logic [WIDTH-1:0] w_sel_a;
  logic [WIDTH-1:0] w_sel_b;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .i_req_valid (req_valid),
    .i_rr_ptr    (r_rr_ptr),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx),
    .o_grant_any (w_grant_any)
  );

  // The grant is a subset of req_valid and req_ready equals the grant in
  // IDLE, so any grant in IDLE is a completed request handshake.
  assign w_accept   = (r_state == ST_IDLE) && w_grant_any;
  assign w_rsp_done = (r_state == ST_RESP) && rsp_ready[r_owner];

  assign w_sel_op = req_op[int'(w_grant_idx)*OPW +: OPW];
  assign w_sel_a  = req_a[int'(w_grant_idx)*WIDTH +: WIDTH];
  assign w_sel_b  = req_b[int'(w_grant_idx)*WIDTH +: WIDTH];

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)   w_state_nxt = ST_EXEC;
      ST_EXEC:                 w_state_nxt = ST_RESP;
      ST_RESP: if (w_rsp_done) w_state_nxt = ST_IDLE;
      default:                 w_state_nxt = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    busy      = (r_state != ST_IDLE);
    if (r_state == ST_IDLE) begin
      req_ready = w_grant;
    end
    for (int i = 0; i < N_REQ; i++) begin
      rsp_valid[i] = (r_state == ST_RESP) && (r_owner == IDX_W'(i));
    end
  end

  // --------------------------------------------------------------------------
  // Datapath registers. The ALU drive registers double as the captured
  // request payload: they are loaded on accept, so the ALU sees the operation
  // exactly during EXEC, and are parked at NOP/0 once EXEC ends.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner      <= '0;
      r_rr_ptr     <= IDX_W'(N_REQ - 1);
      r_srca       <= '0;
      r_srcb       <= '0;
      r_ctrl       <= CTRL_IDLE;
      r_rsp_result <= '0;
      r_rsp_zero   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_owner  <= w_grant_idx;
        r_rr_ptr <= w_grant_idx;
        r_srca   <= w_sel_a;
        r_srcb   <= w_sel_b;
        r_ctrl   <= w_sel_op;
      end else if (r_state == ST_EXEC) begin
        r_rsp_result <= alu_result;
        r_rsp_zero   <= alu_zero;
        r_srca       <= '0;
        r_srcb       <= '0;
        r_ctrl       <= CTRL_IDLE;
      end
    end
  end

  assign alu_srca   = r_srca;
  assign alu_srcb   = r_srcb;
  assign alu_ctrl   = r_ctrl;
  assign rsp_result = r_rsp_result;
  assign rsp_zero   = r_rsp_zero;
  assign dbg_state  = r_state;

endmodule
